psum_drain: RTL and testbench

//  Sits directly downstream of the NoC's per-column output psum FIFOs.

---
 rtl/psum_drain.sv | 145 ++++++++++++++
 tb/tb_psum_drain.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// Drains per-column FWFT psum FIFOs in output-row order, applies shift/ReLU/saturate,
// and writes the ofmap row-major through a single valid/ready output register.
module psum_drain #(
   parameter int G_ARRAY_WIDTH  = 4,
   parameter int G_TOP_BITS     = 2,
   parameter int G_BOT_BITS     = 14,
   parameter int G_KERNEL_SIZE  = 5,
   parameter int G_IMAGE_HEIGHT = 28,
   parameter int G_IMAGE_WIDTH  = 28,
   parameter int G_OUT_BITS     = 8,
   parameter int G_SHIFT        = 7,
   parameter int G_RELU         = 1,
   localparam int PSUM_W = G_TOP_BITS + G_BOT_BITS,
   localparam int OUT_H  = G_IMAGE_HEIGHT - G_KERNEL_SIZE + 1,
   localparam int OUT_W  = G_IMAGE_WIDTH - G_KERNEL_SIZE + 1,
   localparam int N_OUT  = OUT_H * OUT_W,
   localparam int ADDR_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              start_i,
   input  logic [G_ARRAY_WIDTH*PSUM_W-1:0]   psum_i,
   input  logic [G_ARRAY_WIDTH-1:0]          psum_empty_i,
   output logic [G_ARRAY_WIDTH-1:0]          psum_rd_en_o,
   output logic                              ofmap_vld_o,
   input  logic                              ofmap_ready_i,
   output logic [ADDR_W-1:0]                 ofmap_addr_o,
   output logic [G_OUT_BITS-1:0]             ofmap_data_o,
   output logic                              busy_o,
   output logic                              done_o
);

   localparam int SEL_W   = (G_ARRAY_WIDTH > 1) ? $clog2(G_ARRAY_WIDTH) : 1;
   localparam int ROW_W   = $clog2(OUT_H + 1);
   localparam int COL_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int SAT_MAX = (1 << (G_OUT_BITS - 1)) - 1;
   localparam int SAT_MIN = -(1 << (G_OUT_BITS - 1));

   typedef enum logic [1:0] {IDLE_S, DRAIN_S, FLUSH_S} state_t;

   state_t                  state_reg;
   logic [SEL_W-1:0]        sel_reg;
   logic [ROW_W-1:0]        row_reg;
   logic [COL_W-1:0]        col_reg;
   logic [ADDR_W-1:0]       cnt_reg;
   logic                    vld_reg;
   logic [ADDR_W-1:0]       addr_reg;
   logic [G_OUT_BITS-1:0]   data_reg;
   logic                    done_reg;

   logic [PSUM_W-1:0]        psum_sel;
   logic signed [PSUM_W-1:0] shifted;
   int                       y_val;
   logic [G_OUT_BITS-1:0]    data_next;
   logic                     pop;
   logic                     row_end;
   logic                     last_pop;

   assign psum_sel = psum_i[sel_reg*PSUM_W +: PSUM_W];
   assign pop      = (state_reg == DRAIN_S) && !psum_empty_i[sel_reg] &&
                     (!vld_reg || ofmap_ready_i);
   assign row_end  = (col_reg == COL_W'(OUT_W - 1));
   assign last_pop = pop && row_end && (row_reg == ROW_W'(OUT_H - 1));

   always_comb begin
      shifted = $signed(psum_sel) >>> G_SHIFT;
      y_val   = int'(shifted);
      if (G_RELU != 0 && y_val < 0)
         y_val = 0;
      if (y_val > SAT_MAX)
         y_val = SAT_MAX;
      else if (y_val < SAT_MIN)
         y_val = SAT_MIN;
      data_next = G_OUT_BITS'(y_val);
   end

   // FWFT FIFOs: the pop strobe is issued in the same cycle the head is captured.
   generate
      for (genvar gi = 0; gi < G_ARRAY_WIDTH; gi++) begin : g_rd_en
         assign psum_rd_en_o[gi] = pop && (sel_reg == SEL_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= IDLE_S;
         sel_reg   <= '0;
         row_reg   <= '0;
         col_reg   <= '0;
         cnt_reg   <= '0;
         vld_reg   <= 1'b0;
         addr_reg  <= '0;
         data_reg  <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE_S: begin
               if (start_i) begin
                  state_reg <= DRAIN_S;
                  sel_reg   <= '0;
                  row_reg   <= '0;
                  col_reg   <= '0;
                  cnt_reg   <= '0;
               end
            end
            DRAIN_S: begin
               if (pop) begin
                  vld_reg  <= 1'b1;
                  addr_reg <= cnt_reg;
                  data_reg <= data_next;
                  cnt_reg  <= cnt_reg + 1'b1;
                  if (row_end) begin
                     col_reg <= '0;
                     row_reg <= row_reg + 1'b1;
                     // Row r lives in column r mod width: advance a wrap counter.
                     sel_reg <= (sel_reg == SEL_W'(G_ARRAY_WIDTH - 1)) ? '0 : sel_reg + 1'b1;
                  end else begin
                     col_reg <= col_reg + 1'b1;
                  end
                  if (last_pop)
                     state_reg <= FLUSH_S;
               end else if (ofmap_ready_i) begin
                  vld_reg <= 1'b0;
               end
            end
            FLUSH_S: begin
               if (vld_reg && ofmap_ready_i) begin
                  vld_reg   <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= IDLE_S;
               end
            end
            default: state_reg <= IDLE_S;
         endcase
      end
   end

   assign ofmap_vld_o  = vld_reg;
   assign ofmap_addr_o = addr_reg;
   assign ofmap_data_o = data_reg;
   assign busy_o       = (state_reg == DRAIN_S);
   assign done_o       = done_reg;

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: FWFT FIFO models per column, expected writes queued
// in address order, plus a second instance with ReLU disabled sharing all inputs.
module tb_psum_drain;

   localparam int W  = 4;
   localparam int PW = 16;
   localparam int OH = 24;
   localparam int OW = 24;
   localparam int N  = OH * OW;
   localparam int BUDGET = 5000;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [W*PW-1:0] psum_i;
   logic [W-1:0]  psum_empty_i;
   logic          ofmap_ready_i;
   logic [W-1:0]  rd_en, rd_en2;
   logic          vld, vld2;
   logic [9:0]    addr, addr2;
   logic [7:0]    data, data2;
   logic          busy, busy2, done, done2;

   always #5 clk_i = ~clk_i;

   psum_drain dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .psum_i(psum_i),
      .psum_empty_i(psum_empty_i), .psum_rd_en_o(rd_en), .ofmap_vld_o(vld),
      .ofmap_ready_i(ofmap_ready_i), .ofmap_addr_o(addr), .ofmap_data_o(data),
      .busy_o(busy), .done_o(done)
   );

   psum_drain #(.G_RELU(0)) dut_norelu (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .psum_i(psum_i),
      .psum_empty_i(psum_empty_i), .psum_rd_en_o(rd_en2), .ofmap_vld_o(vld2),
      .ofmap_ready_i(ofmap_ready_i), .ofmap_addr_o(addr2), .ofmap_data_o(data2),
      .busy_o(busy2), .done_o(done2)
   );

   int           n_checks = 0;
   int           n_errors = 0;
   logic [15:0]  fifo_q[W][$];
   int           exp_addr_q[$];
   logic [7:0]   exp_d1_q[$];
   logic [7:0]   exp_d0_q[$];
   logic [15:0]  val_tab[N];
   logic [7:0]   got_d1[4];
   logic [7:0]   got_d0[4];
   int           cyc = 0, pop_cnt = 0, accepted = 0;
   int           last_acc_cyc = 0, first_acc_cyc = -1, done_cnt = 0;
   bit           pop_pend = 0, hold_pend = 0, rnd_mode = 0;
   logic [9:0]   hold_addr;
   logic [7:0]   hold_data;
   logic [W-1:0] pop_mask;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Floor division by 2^7, then optional ReLU and clamp to signed 8 bits.
   function automatic logic [7:0] model(input logic [15:0] p, input bit relu);
      int v, q;
      v = int'($signed(p));
      q = (v >= 0) ? v / 128 : -((-v + 127) / 128);
      if (relu && q < 0) q = 0;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return q[7:0];
   endfunction

   task automatic refresh();
      for (int c = 0; c < W; c++) begin
         psum_empty_i[c] = (fifo_q[c].size() == 0);
         psum_i[c*PW +: PW] = (fifo_q[c].size() > 0) ? fifo_q[c][0] : 16'h0;
      end
   endtask

   task automatic fill_col(input int c);
      for (int a = 0; a < N; a++)
         if (((a / OW) % W) == c) fifo_q[c].push_back(val_tab[a]);
   endtask

   task automatic prep(input logic [W-1:0] col_mask);
      for (int c = 0; c < W; c++) begin
         fifo_q[c].delete();
         if (col_mask[c]) fill_col(c);
      end
      exp_addr_q.delete(); exp_d1_q.delete(); exp_d0_q.delete();
      for (int a = 0; a < N; a++) begin
         exp_addr_q.push_back(a);
         exp_d1_q.push_back(model(val_tab[a], 1'b1));
         exp_d0_q.push_back(model(val_tab[a], 1'b0));
      end
      pop_cnt = 0; accepted = 0; first_acc_cyc = -1;
      refresh();
   endtask

   // One clock: check at negedge, then apply FIFO pops and new inputs at posedge+1.
   task automatic step();
      int col, ea;
      @(negedge clk_i);
      cyc++;
      if (done) begin
         done_cnt++;
         check("done_latency", cyc - last_acc_cyc, 1);
         check("done_at_count", accepted, N);
         check("norelu_done", done2, 1);
      end
      if (pop_pend) check("pop_to_vld", vld, 1);
      if (hold_pend) begin
         check("hold_vld", vld, 1);
         check("hold_addr", addr, hold_addr);
         check("hold_data", data, hold_data);
      end
      pop_mask = rd_en;
      pop_pend = (rd_en != 0);
      if (rd_en != 0) begin
         col = (pop_cnt / OW) % W;
         check("rd_en_col", rd_en, 1 << col);
         check("norelu_rd_en", rd_en2, 1 << col);
         check("pop_nonempty", fifo_q[col].size() > 0, 1);
         pop_cnt++;
      end
      if (vld && ofmap_ready_i) begin
         if (exp_addr_q.size() == 0) begin
            check("sb_underflow", accepted, N);
         end else begin
            ea = exp_addr_q.pop_front();
            check("addr", addr, ea);
            check("data", data, exp_d1_q.pop_front());
            check("norelu_data", data2, exp_d0_q.pop_front());
            check("norelu_vld", vld2, 1);
            check("norelu_addr", addr2, ea);
            if (ea < 4) begin
               got_d1[ea] = data;
               got_d0[ea] = data2;
            end
         end
         accepted++;
         if (first_acc_cyc < 0) first_acc_cyc = cyc;
         last_acc_cyc = cyc;
      end
      hold_pend = vld && !ofmap_ready_i;
      hold_addr = addr;
      hold_data = data;
      @(posedge clk_i);
      #1;
      for (int c = 0; c < W; c++)
         if (pop_mask[c] && fifo_q[c].size() > 0) void'(fifo_q[c].pop_front());
      if (rnd_mode) begin
         ofmap_ready_i = ($urandom_range(0, 1) == 1);
         start_i = (accepted < 500) && ($urandom_range(0, 7) == 0);
      end
      refresh();
   endtask

   task automatic start_drain();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic run_drain(input int stop_at);
      int n = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && n < BUDGET && !(stop_at > 0 && accepted >= stop_at)) begin
         step();
         n++;
      end
      check("drain_in_budget", n < BUDGET, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      int stall_pops, dc;
      for (int a = 0; a < N; a++) begin
         r = $urandom;
         val_tab[a] = r[16] ? r[15:0] : {{2{r[13]}}, r[13:0]};
      end
      val_tab[0] = 16'h4000;
      val_tab[1] = 16'h2000;
      val_tab[2] = 16'hFF80;
      val_tab[3] = 16'h8000;

      rst_i = 1'b1; start_i = 1'b0; ofmap_ready_i = 1'b1;
      psum_i = '0; psum_empty_i = '1;
      #22;
      rst_i = 1'b0;
      @(negedge clk_i);
      check("rst_vld", vld, 0);
      check("rst_addr", addr, 0);
      check("rst_data", data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_norelu_busy", busy2, 0);
      @(posedge clk_i); #1;

      // Idle with full FIFOs: nothing may be popped.
      prep('1);
      stall_pops = 0;
      repeat (100) begin
         step();
         if (pop_mask != 0) stall_pops++;
      end
      check("idle_no_pop", stall_pops, 0);

      // Full-rate drain with preloaded FIFOs.
      start_drain();
      run_drain(-1);
      check("full_accepted", accepted, N);
      check("full_throughput", last_acc_cyc - first_acc_cyc, N - 1);
      check("full_sb_empty", exp_addr_q.size(), 0);
      check("full_done_cnt", done_cnt, 1);
      check("arith_one_sat", got_d1[0], 8'h7F);
      check("arith_half", got_d1[1], 8'h40);
      check("arith_neg_relu", got_d1[2], 8'h00);
      check("arith_neg_norelu", got_d0[2], 8'hFF);
      check("arith_min_norelu", got_d0[3], 8'h80);
      check("idle_busy", busy, 0);

      // Random backpressure with ignored start pulses.
      prep('1);
      start_drain();
      rnd_mode = 1;
      run_drain(-1);
      rnd_mode = 0; start_i = 1'b0; ofmap_ready_i = 1'b1;
      check("rnd_accepted", accepted, N);
      check("rnd_sb_empty", exp_addr_q.size(), 0);
      check("rnd_done_cnt", done_cnt, 2);

      // Column 1 empty after row 0: must stall, never skip ahead.
      prep(4'b1101);
      start_drain();
      run_drain(24);
      step(); step();
      stall_pops = 0;
      repeat (20) begin
         step();
         if (pop_mask != 0) stall_pops++;
      end
      check("stall_no_pop", stall_pops, 0);
      check("stall_accepted", accepted, 24);
      check("stall_vld", vld, 0);
      check("stall_busy", busy, 1);
      fill_col(1);
      refresh();
      run_drain(-1);
      check("stall_resume_accepted", accepted, N);
      check("stall_done_cnt", done_cnt, 3);

      // Async reset mid-drain, then a clean restart from address 0.
      prep('1);
      start_drain();
      run_drain(300);
      #2;
      rst_i = 1'b1;
      pop_pend = 0; hold_pend = 0;
      #1;
      check("abort_vld", vld, 0);
      check("abort_addr", addr, 0);
      check("abort_data", data, 0);
      check("abort_busy", busy, 0);
      check("abort_rd_en", rd_en, 0);
      dc = done_cnt;
      repeat (3) step();
      check("abort_no_done", done_cnt, dc);
      #3;
      rst_i = 1'b0;
      repeat (5) step();
      check("abort_idle_no_done", done_cnt, dc);
      prep('1);
      start_drain();
      run_drain(-1);
      check("restart_accepted", accepted, N);
      check("restart_sb_empty", exp_addr_q.size(), 0);
      check("restart_done_cnt", done_cnt, dc + 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
